// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide: shift-add multiply, restoring divide,
// one operand bit per cycle, fixed latency independent of operand values.
module muldiv_unit #(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [1:0]      Op,
  input  logic [BITS-1:0] SrcA,
  input  logic [BITS-1:0] SrcB,
  output logic            Busy,
  output logic            Done,
  output logic [BITS-1:0] Result,
  output logic            DivZero
);

  localparam int CW = $clog2(BITS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [1:0]      op_q;
  logic [BITS-1:0] opnd_q;
  logic [BITS-1:0] hi_q, hi_d;
  logic [BITS-1:0] lo_q, lo_d;
  logic [CW-1:0]   cnt_q;
  logic [BITS:0]   sum, shifted, trial;

  // hi/lo form one double-width register: product for multiply,
  // remainder:dividend/quotient for divide. opnd_q is the adder operand.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[BITS-1]};
    trial   = shifted - {1'b0, opnd_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (!op_q[1]) begin
      hi_d = sum[BITS:1];
      lo_d = {sum[0], lo_q[BITS-1:1]};
    end else if (!trial[BITS]) begin
      hi_d = trial[BITS-1:0];
      lo_d = {lo_q[BITS-2:0], 1'b1};
    end else begin
      hi_d = shifted[BITS-1:0];
      lo_d = {lo_q[BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Result  <= '0;
      DivZero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            op_q    <= Op;
            opnd_q  <= Op[1] ? SrcB : SrcA;
            lo_q    <= Op[1] ? SrcA : SrcB;
            hi_q    <= '0;
            cnt_q   <= '0;
            Busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(BITS - 1)) begin
            // Low half holds MUL/DIVU, high half MULHU/REMU.
            Result  <= op_q[0] ? hi_d : lo_d;
            DivZero <= op_q[1] && (opnd_q == '0);
            Busy    <= 1'b0;
            Done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          Done    <= 1'b0;
          DivZero <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
